// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: coin/result codes,
// FSM state encoding and coin values in 5-cent units.
package change_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_CANCEL = 2'b01,
    RES_EXACT  = 2'b10,
    RES_CHANGE = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_DISPENSE = 2'b01,
    S_DONE     = 2'b10
  } state_e;

  localparam logic [3:0] VAL_5C  = 4'd1;
  localparam logic [3:0] VAL_10C = 4'd2;
  localparam logic [3:0] VAL_25C = 4'd5;

endpackage

// File: rtl/change_dispenser_if.sv
// Vend-result input and coin-ejector handshake bundle for change_dispenser.
interface change_dispenser_if;
  logic [1:0] result;
  logic       result_valid;
  logic [3:0] credit;
  logic       busy;
  logic       vend;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ack;
  logic       done;
  logic       error;

  modport slave (
    input  result, result_valid, credit, coin_ack,
    output busy, vend, coin, coin_valid, done, error
  );

  modport master (
    output result, result_valid, credit, coin_ack,
    input  busy, vend, coin, coin_valid, done, error
  );
endinterface

// File: rtl/coin_select.sv
// Greedy coin choice for the remaining refund (5-cent units).
module coin_select
  import change_pkg::*;
(
  input  logic [3:0] remaining_i,
  output coin_e      coin_o,
  output logic [3:0] value_o
);

  always_comb begin
    coin_o  = COIN_5;
    value_o = VAL_5C;
    if (remaining_i >= VAL_25C) begin
      coin_o  = COIN_25;
      value_o = VAL_25C;
    end else if (remaining_i >= VAL_10C) begin
      coin_o  = COIN_10;
      value_o = VAL_10C;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Vend result -> item release plus greedy coin refund over an ack handshake.
// Optional ACK_TIMEOUT_EN aborts a refund whose coin is never acknowledged.
module change_dispenser
  import change_pkg::*;
#(
  parameter int PRICE   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  localparam logic [3:0] PRICE_U = 4'(PRICE);

  state_e     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic       vend_q, vend_d;
  logic [3:0] refund;
  result_e    res;
  coin_e      sel_coin;
  logic [3:0] sel_val;

`ifdef ACK_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`endif

  assign res = result_e'(bus.result);

  coin_select u_sel (
    .remaining_i (rem_q),
    .coin_o      (sel_coin),
    .value_o     (sel_val)
  );

  // Change below the price yields nothing rather than wrapping.
  always_comb begin
    refund = '0;
    case (res)
      RES_CANCEL: refund = bus.credit;
      RES_CHANGE: if (bus.credit > PRICE_U) refund = bus.credit - PRICE_U;
      default:    refund = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vend_d  = 1'b0;
`ifdef ACK_TIMEOUT_EN
    wait_d  = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.result_valid && res != RES_NONE) begin
          vend_d  = res[1];
          rem_d   = refund;
          state_d = (refund == '0) ? S_DONE : S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (bus.coin_ack) begin
          rem_d = rem_q - sel_val;
          if (rem_q == sel_val) state_d = S_DONE;
        end
`ifdef ACK_TIMEOUT_EN
        else if (wait_q == TW'(TIMEOUT - 1)) begin
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      vend_q  <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vend_q  <= vend_d;
`ifdef ACK_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.vend       = vend_q;
  assign bus.coin_valid = (state_q == S_DISPENSE);
  assign bus.coin       = bus.coin_valid ? sel_coin : COIN_NONE;
  assign bus.done       = (state_q == S_DONE);
`ifdef ACK_TIMEOUT_EN
  assign bus.error      = err_q;
`else
  assign bus.error      = 1'b0;
`endif

endmodule
